// File: rtl/exe_seq_pkg.sv
// Shared encodings for the exe_seq instruction sequencer: state codes,
// instruction word layout and operand widths.
package exe_seq_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPER_W  = 3;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned DATA_W  = 6;
    localparam int unsigned FLAG_W  = 4;

    localparam int unsigned OPER_MSB = 15;
    localparam int unsigned OPER_LSB = 13;
    localparam int unsigned IMM_BIT  = 12;
    localparam int unsigned DEST_MSB = 11;
    localparam int unsigned DEST_LSB = 8;
    localparam int unsigned SRCA_MSB = 7;
    localparam int unsigned SRCA_LSB = 4;
    localparam int unsigned SRCB_MSB = 3;
    localparam int unsigned SRCB_LSB = 0;
    localparam int unsigned IMMV_MSB = 5;
    localparam int unsigned IMMV_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IMM   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    typedef struct packed {
        logic [OPER_W-1:0] oper;
        logic              imm;
        logic [REG_W-1:0]  dest;
        logic [REG_W-1:0]  src_a;
        logic [REG_W-1:0]  src_b;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.oper  = w[OPER_MSB:OPER_LSB];
        d.imm   = w[IMM_BIT];
        d.dest  = w[DEST_MSB:DEST_LSB];
        d.src_a = w[SRCA_MSB:SRCA_LSB];
        d.src_b = w[SRCB_MSB:SRCB_LSB];
        return d;
    endfunction

endpackage

// File: rtl/exe_seq_fsm.sv
// Sequencer control: IDLE -> (IMM) -> ISSUE -> WB -> IDLE, with registered
// ready/busy so they are glitch-free at the handshake boundary.
module exe_seq_fsm
    import exe_seq_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   valid_i,
    input  logic   imm_i,
    output state_e state_o,
    output logic   ready_o,
    output logic   busy_o
);

    state_e state_q, state_d;
    logic   ready_q;
    logic   busy_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (valid_i && ready_q) state_d = imm_i ? ST_IMM : ST_ISSUE;
            ST_IMM:   if (valid_i && ready_q) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ready/busy are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE) || (state_d == ST_IMM);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign state_o = state_q;
    assign ready_o = ready_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/exe_seq.sv
// Instruction sequencer feeding the execute stage operands and writing the
// execute result back through reg2/wdata during the WB cycle only.
module exe_seq
    import exe_seq_pkg::*;
#(
    parameter int unsigned SINK_REG = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rsn,
    input  logic [INSTR_W-1:0]       i_instr,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [DATA_W-1:0] i_res,
    input  logic [FLAG_W-1:0]        i_flag,
    output logic [OPER_W-1:0]        o_oper,
    output logic [REG_W-1:0]         o_reg0,
    output logic [REG_W-1:0]         o_reg1,
    output logic [REG_W-1:0]         o_reg2,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_imm,
    output logic signed [DATA_W-1:0] o_wdata,
    output logic [FLAG_W-1:0]        o_flag,
    output logic                     o_busy,
    output logic [CNT_W-1:0]         o_icnt
);

    localparam logic [REG_W-1:0] SINK = REG_W'(SINK_REG);

    state_e state;
    logic   xfer;
    instr_t dec;

    instr_t                     hdr_q,   hdr_d;
    logic [OPER_W-1:0]          oper_q,  oper_d;
    logic [REG_W-1:0]           reg0_q,  reg0_d;
    logic [REG_W-1:0]           reg1_q,  reg1_d;
    logic signed [DATA_W-1:0]   data_q,  data_d;
    logic                       imm_q,   imm_d;
    logic signed [DATA_W-1:0]   wdata_q, wdata_d;
    logic [FLAG_W-1:0]          flag_q,  flag_d;
    logic [CNT_W-1:0]           icnt_q,  icnt_d;

    assign dec  = decode(i_instr);
    assign xfer = i_valid && o_ready;

    exe_seq_fsm u_fsm (
        .clk_i   (i_clk),
        .rst_ni  (i_rsn),
        .valid_i (i_valid),
        .imm_i   (dec.imm),
        .state_o (state),
        .ready_o (o_ready),
        .busy_o  (o_busy)
    );

    // Operand outputs load only on entry to ISSUE; the header is parked in
    // hdr_q while IMM waits, so outputs keep the previous instruction meanwhile.
    always_comb begin
        hdr_d   = hdr_q;
        oper_d  = oper_q;
        reg0_d  = reg0_q;
        reg1_d  = reg1_q;
        data_d  = data_q;
        imm_d   = imm_q;
        wdata_d = wdata_q;
        flag_d  = flag_q;
        icnt_d  = icnt_q;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    hdr_d = dec;
                    if (!dec.imm) begin
                        oper_d = dec.oper;
                        reg0_d = dec.src_a;
                        reg1_d = dec.src_b;
                        imm_d  = 1'b0;
                        data_d = '0;
                    end
                end
            end
            ST_IMM: begin
                if (xfer) begin
                    oper_d = hdr_q.oper;
                    reg0_d = hdr_q.src_a;
                    reg1_d = hdr_q.src_b;
                    imm_d  = hdr_q.imm;
                    data_d = i_instr[IMMV_MSB:IMMV_LSB];
                end
            end
            ST_ISSUE: begin
                wdata_d = i_res;
                flag_d  = i_flag;
            end
            ST_WB: begin
                icnt_d = icnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            hdr_q   <= '0;
            oper_q  <= '0;
            reg0_q  <= '0;
            reg1_q  <= '0;
            data_q  <= '0;
            imm_q   <= 1'b0;
            wdata_q <= '0;
            flag_q  <= '0;
            icnt_q  <= '0;
        end else begin
            hdr_q   <= hdr_d;
            oper_q  <= oper_d;
            reg0_q  <= reg0_d;
            reg1_q  <= reg1_d;
            data_q  <= data_d;
            imm_q   <= imm_d;
            wdata_q <= wdata_d;
            flag_q  <= flag_d;
            icnt_q  <= icnt_d;
        end
    end

    assign o_oper  = oper_q;
    assign o_reg0  = reg0_q;
    assign o_reg1  = reg1_q;
    assign o_data  = data_q;
    assign o_imm   = imm_q;
    assign o_flag  = flag_q;
    assign o_icnt  = icnt_q;
    // Outside WB the register file only ever sees a write of 0 to the scratch register.
    assign o_reg2  = (state == ST_WB) ? hdr_q.dest : SINK;
    assign o_wdata = (state == ST_WB) ? wdata_q : '0;

endmodule
